// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing one registered MMIO slave port among NUM_MST masters,
// with read-data routing by grant ID. Optional master locking under `MMIO_ARB_LOCK_EN.
module mmio_arbiter #(
  parameter int NUM_MST    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MST-1:0]                m_wr_en,
  input  logic [NUM_MST-1:0]                m_rd_en,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]     m_addr,
  input  logic [NUM_MST*DATA_WIDTH-1:0]     m_wr_data,
  input  logic [NUM_MST*DATA_WIDTH/8-1:0]   m_wr_byteen,
`ifdef MMIO_ARB_LOCK_EN
  input  logic [NUM_MST-1:0]                m_lock,
`endif
  output logic [NUM_MST-1:0]                m_ack,
  output logic [NUM_MST-1:0]                m_rd_valid,
  output logic [DATA_WIDTH-1:0]             m_rd_data,
  output logic                              s_wr_en,
  output logic [ADDR_WIDTH-1:0]             s_wr_addr,
  output logic [DATA_WIDTH-1:0]             s_wr_data,
  output logic [DATA_WIDTH/8-1:0]           s_wr_byteen,
  output logic                              s_rd_en,
  output logic [ADDR_WIDTH-1:0]             s_rd_addr,
  input  logic [DATA_WIDTH-1:0]             s_rd_data
);

  localparam int ID_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int BE_W = DATA_WIDTH / 8;

  // Handshake: a master raises wr_en/rd_en with stable fields and holds them until
  // its m_ack bit is seen high in the same cycle; the transaction is then complete.

  logic [NUM_MST-1:0] req;
  logic [NUM_MST-1:0] eligible;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_id;
  logic               grant_vld;
  logic [ID_W-1:0]    s_id;

  logic [RD_LATENCY-1:0] pipe_vld;
  logic [ID_W-1:0]       pipe_id [RD_LATENCY];

  assign req = m_wr_en | m_rd_en;

`ifdef MMIO_ARB_LOCK_EN
  logic            locked;
  logic [ID_W-1:0] lock_id;

  // While locked, only the lock owner may win arbitration.
  always_comb begin
    eligible = req;
    if (locked) eligible = req & (NUM_MST'(1) << lock_id);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked  <= 1'b0;
      lock_id <= '0;
    end else if (grant_vld) begin
      locked  <= m_lock[grant_id];
      lock_id <= grant_id;
    end
  end
`else
  assign eligible = req;
`endif

  // Search starts just above the last winner and wraps, giving rotating priority.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NUM_MST; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_MST) idx = idx - NUM_MST;
      idx_w = idx[ID_W-1:0];
      if (!grant_vld && eligible[idx_w]) begin
        grant_vld = 1'b1;
        grant_id  = idx_w;
      end
    end
  end

  always_comb begin
    m_ack = '0;
    if (grant_vld && rst_n) m_ack[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= ID_W'(NUM_MST - 1);
      s_wr_en     <= 1'b0;
      s_rd_en     <= 1'b0;
      s_wr_addr   <= '0;
      s_rd_addr   <= '0;
      s_wr_data   <= '0;
      s_wr_byteen <= '0;
      s_id        <= '0;
    end else begin
      s_wr_en <= grant_vld & m_wr_en[grant_id];
      s_rd_en <= grant_vld & m_rd_en[grant_id];
      if (grant_vld) begin
        ptr         <= grant_id;
        s_wr_addr   <= m_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
        s_rd_addr   <= m_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
        s_wr_data   <= m_wr_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        s_wr_byteen <= m_wr_byteen[grant_id*BE_W +: BE_W];
        s_id        <= grant_id;
      end
    end
  end

  // Owner of each issued read travels alongside the slave's fixed latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int k = 0; k < RD_LATENCY; k++) pipe_id[k] <= '0;
    end else begin
      pipe_vld[0] <= s_rd_en;
      pipe_id[0]  <= s_id;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_id[k]  <= pipe_id[k-1];
      end
    end
  end

  always_comb begin
    m_rd_valid = '0;
    if (pipe_vld[RD_LATENCY-1]) m_rd_valid[pipe_id[RD_LATENCY-1]] = 1'b1;
  end

  assign m_rd_data = s_rd_data;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed and randomized checks of mmio_arbiter against a transaction-level model
// (rotating priority, expected read returns queued with their due cycle).
module tb_mmio_arbiter;

  localparam int N      = 4;
  localparam int AW     = 32;
  localparam int DW     = 64;
  localparam int BE_W   = DW / 8;
  localparam int ID_W   = 2;
  localparam int RD_LAT = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // master-side stimulus
  logic [N-1:0]    wr, rd, lock;
  logic [AW-1:0]   addr  [N];
  logic [DW-1:0]   wdata [N];
  logic [BE_W-1:0] be    [N];

  logic [N*AW-1:0]   m_addr_v;
  logic [N*DW-1:0]   m_wr_data_v;
  logic [N*BE_W-1:0] m_wr_byteen_v;
  logic [N-1:0]      m_ack, m_rd_valid;
  logic [DW-1:0]     m_rd_data;
  logic              s_wr_en, s_rd_en;
  logic [AW-1:0]     s_wr_addr, s_rd_addr;
  logic [DW-1:0]     s_wr_data, s_rd_data;
  logic [BE_W-1:0]   s_wr_byteen;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_addr_v[i*AW +: AW]        = addr[i];
      m_wr_data_v[i*DW +: DW]     = wdata[i];
      m_wr_byteen_v[i*BE_W +: BE_W] = be[i];
    end
  end

  mmio_arbiter #(.NUM_MST(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_wr_en(wr), .m_rd_en(rd), .m_addr(m_addr_v),
    .m_wr_data(m_wr_data_v), .m_wr_byteen(m_wr_byteen_v),
`ifdef MMIO_ARB_LOCK_EN
    .m_lock(lock),
`endif
    .m_ack(m_ack), .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data),
    .s_wr_en(s_wr_en), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
    .s_wr_byteen(s_wr_byteen), .s_rd_en(s_rd_en), .s_rd_addr(s_rd_addr),
    .s_rd_data(s_rd_data)
  );

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    if (a == 32'h100) return 64'hDEAD;
    return {a, a ^ 32'h5A5A_A5A5};
  endfunction

  // slave: fixed read latency from s_rd_en
  logic [DW-1:0] sl_pipe [RD_LAT];
  always @(posedge clk) begin
    sl_pipe[0] <= s_rd_en ? slave_data(s_rd_addr) : '0;
    for (int k = 1; k < RD_LAT; k++) sl_pipe[k] <= sl_pipe[k-1];
  end
  assign s_rd_data = sl_pipe[RD_LAT-1];

  // scoreboard / reference model
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mptr;
  bit mlock;
  int mlock_id;
  logic            exp_swe, exp_sre;
  logic [AW-1:0]   exp_waddr, exp_raddr;
  logic [DW-1:0]   exp_wdata;
  logic [BE_W-1:0] exp_be;
  logic [ID_W+DW-1:0] exp_q [$];
  int                 due_q [$];
  logic [N-1:0]  obs_ack, obs_rv;
  logic [DW-1:0] obs_rd;
  logic          obs_sre;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mptr = N - 1;
    mlock = 1'b0;
    mlock_id = 0;
    exp_swe = 1'b0; exp_sre = 1'b0;
    exp_waddr = '0; exp_raddr = '0; exp_wdata = '0; exp_be = '0;
    exp_q.delete();
    due_q.delete();
  endtask

  // one clock: check outputs mid-cycle, advance the model, clear the acked master
  task automatic tick();
    logic [N-1:0]       req, exp_ack, exp_rv;
    logic [ID_W+DW-1:0] ent;
    int g, c;
    @(negedge clk);
    obs_ack = m_ack; obs_rv = m_rd_valid; obs_rd = m_rd_data; obs_sre = s_rd_en;
    if (!rst_n) model_reset();
    req = wr | rd;
    g = -1;
    if (rst_n) begin
      for (int k = 1; k <= N; k++) begin
        c = (mptr + k) % N;
        if (g < 0 && req[c] && (!mlock || c == mlock_id)) g = c;
      end
    end
    exp_ack = (g >= 0) ? N'(1 << g) : '0;
    chk("m_ack", obs_ack, exp_ack);
    chk("s_wr_en", s_wr_en, exp_swe);
    chk("s_rd_en", s_rd_en, exp_sre);
    chk("s_wr_addr", s_wr_addr, exp_waddr);
    chk("s_rd_addr", s_rd_addr, exp_raddr);
    chk("s_wr_data", s_wr_data, exp_wdata);
    chk("s_wr_byteen", s_wr_byteen, exp_be);
    exp_rv = '0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      ent = exp_q.pop_front();
      exp_rv = N'(1 << ent[ID_W+DW-1:DW]);
      chk("m_rd_data", obs_rd, ent[DW-1:0]);
    end
    chk("m_rd_valid", obs_rv, exp_rv);
    if (rst_n) begin
      if (g >= 0) begin
        exp_swe = wr[g]; exp_sre = rd[g];
        exp_waddr = addr[g]; exp_raddr = addr[g];
        exp_wdata = wdata[g]; exp_be = be[g];
        if (rd[g]) begin
          due_q.push_back(cyc + 1 + RD_LAT);
          exp_q.push_back({ID_W'(g), slave_data(addr[g])});
        end
        mptr = g;
`ifdef MMIO_ARB_LOCK_EN
        mlock = lock[g];
        mlock_id = g;
`endif
      end else begin
        exp_swe = 1'b0; exp_sre = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) begin
      wr[g] = 1'b0;
      rd[g] = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    wr = '0; rd = '0; lock = '0;
    for (int i = 0; i < N; i++) begin
      addr[i]  = 32'h1000 + 32'(i * 16);
      wdata[i] = {32'hA0 + 32'(i), 32'h5500 + 32'(i)};
      be[i]    = BE_W'(8'hF0 | i);
    end
    model_reset();

    // requests present while held in reset must not be acked
    wr = '1;
    tick();
    tick();
    chk("reset_ack", obs_ack, '0);
    chk("reset_rd_en", obs_sre, '0);
    rst_n = 1'b1;

    // all four write together: rotating order 0,1,2,3
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_order", obs_ack, 64'(1 << k));
    end
    repeat (2) tick();

    // master 2 reads 0x100
    rd[2] = 1'b1; addr[2] = 32'h100;
    for (int k = 0; k <= RD_LAT + 1; k++) begin
      tick();
      if (k == 0) chk("rd2_ack", obs_ack, 4'b0100);
      if (k == 1) chk("rd2_s_rd_en", obs_sre, 1'b1);
      if (k == RD_LAT + 1) begin
        chk("rd2_valid", obs_rv, 4'b0100);
        chk("rd2_data", obs_rd, 64'hDEAD);
      end
    end

    // back-to-back reads from masters 0 then 3
    rd[0] = 1'b1; addr[0] = 32'h200;
    tick();
    rd[3] = 1'b1; addr[3] = 32'h300;
    tick();
    for (int j = 0; j <= RD_LAT; j++) begin
      tick();
      if (j == RD_LAT - 1) begin
        chk("b2b_valid0", obs_rv, 4'b0001);
        chk("b2b_data0", obs_rd, slave_data(32'h200));
      end
      if (j == RD_LAT) begin
        chk("b2b_valid3", obs_rv, 4'b1000);
        chk("b2b_data3", obs_rd, slave_data(32'h300));
      end
    end

    // lone master 1 streams, then master 0 joins
    for (int k = 0; k < 6; k++) begin
      wr[1] = 1'b1; addr[1] = 32'h400 + 32'(k * 8);
      tick();
      chk("lone_stream", obs_ack, 4'b0010);
    end
    for (int k = 0; k < 6; k++) begin
      if (!wr[0]) begin wr[0] = 1'b1; addr[0] = 32'h480 + 32'(k * 8); end
      wr[1] = 1'b1; addr[1] = 32'h4C0 + 32'(k * 8);
      tick();
      chk("alternate", obs_ack, (k % 2 == 0) ? 64'h1 : 64'h2);
    end
    wr = '0;
    repeat (RD_LAT + 2) tick();

    // reset while a read is in flight
    rd[2] = 1'b1; addr[2] = 32'h500;
    tick();
    tick();
    rst_n = 1'b0;
    wr[0] = 1'b1; wr[1] = 1'b1; addr[0] = 32'h600; addr[1] = 32'h610;
    tick();
    chk("midrst_rd_en", obs_sre, 1'b0);
    chk("midrst_ack", obs_ack, '0);
    rst_n = 1'b1;
    tick();
    chk("first_after_reset", obs_ack, 4'b0001);
    for (int k = 0; k <= RD_LAT; k++) begin
      tick();
      chk("no_stale_rd_valid", obs_rv, '0);
    end

`ifdef MMIO_ARB_LOCK_EN
    // master 1 locks for three writes while master 0 waits
    wr = '0; rd = '0;
    repeat (2) tick();
    lock[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h700;
    tick();
    chk("lock_ack1", obs_ack, 4'b0010);
    wr[0] = 1'b1; addr[0] = 32'h780;
    for (int k = 1; k < 3; k++) begin
      wr[1] = 1'b1; addr[1] = 32'h700 + 32'(k * 8);
      tick();
      chk("lock_ack1", obs_ack, 4'b0010);
    end
    tick();
    chk("lock_stall", obs_ack, '0);
    lock[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h740;
    tick();
    chk("unlock_ack1", obs_ack, 4'b0010);
    tick();
    chk("lock_release", obs_ack, 4'b0001);
`endif

    // randomized traffic, with one asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!(wr[i] | rd[i]) && $urandom_range(0, 9) < 6) begin
          case ($urandom_range(0, 2))
            0: wr[i] = 1'b1;
            1: rd[i] = 1'b1;
            default: begin wr[i] = 1'b1; rd[i] = 1'b1; end
          endcase
          addr[i]  = $urandom & 32'hFFFF_FFF8;
          wdata[i] = {$urandom, $urandom};
          be[i]    = BE_W'($urandom_range(0, 255));
`ifdef MMIO_ARB_LOCK_EN
          lock[i]  = ($urandom_range(0, 3) == 0);
`endif
        end
      end
      if (n == 200) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    wr = '0; rd = '0; lock = '0;
    repeat (RD_LAT + 3) tick();
    chk("rd_queue_drained", 64'(due_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
